// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: strips the trailing 4-byte CRC, forwards the
// payload, recomputes the reflected CRC-32 over it and reports per-frame status.
module crc32_frame_checker #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             crc_err,
    output logic             runt,
    output logic [31:0]      rx_crc,
    output logic [31:0]      calc_crc,
    output logic [LEN_W-1:0] frame_len,
    output logic [1:0]       dbg_state
);

    // Handshake: a byte moves when in_valid && in_ready on a rising edge; in_ready
    // depends only on state, and the source holds in_byte/in_last until accepted.

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]      CRC_POLY = 32'hEDB8_8320;
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;

    // One entry of the standard reflected CRC-32 table; synthesises to a 256x32 ROM.
    function automatic logic [31:0] crc_tab(input logic [7:0] idx);
        logic [31:0] v;
        v = {24'h0, idx};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
        end
        return v;
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic              w_in_ready;
    logic              w_frame_done;

    logic [7:0]        r_hold [0:3];
    logic [2:0]        r_fill;
    logic [31:0]       r_crc;
    logic [LEN_W-1:0]  r_len;

    logic              r_out_valid;
    logic [7:0]        r_out_byte;

    logic              r_frame_ok;
    logic              r_crc_err;
    logic              r_runt;
    logic [31:0]       r_rx_crc;
    logic [31:0]       r_calc_crc;
    logic [LEN_W-1:0]  r_frame_len;

    logic              w_accept;
    logic              w_restart;
    logic [2:0]        w_fill_base;
    logic [31:0]       w_crc_base;
    logic [LEN_W-1:0]  w_len_base;
    logic              w_emit;
    logic [31:0]       w_crc_upd;
    logic [31:0]       w_rx_asm;
    logic              w_is_runt;
    logic [31:0]       w_calc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (in_valid && in_last) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                w_in_ready   = 1'b0;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_frame_done = 1'b1;
                w_next_state = (in_valid && in_last) ? ST_CHECK : ST_RUN;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // ---------------- datapath ----------------
    assign w_accept    = in_valid && w_in_ready;
    // A byte taken in DONE must see the per-frame state already cleared.
    assign w_restart   = (r_state == ST_DONE);
    assign w_fill_base = w_restart ? 3'd0 : r_fill;
    assign w_crc_base  = w_restart ? CRC_INIT : r_crc;
    assign w_len_base  = w_restart ? '0 : r_len;
    assign w_emit      = w_accept && (w_fill_base == 3'd4);
    assign w_crc_upd   = (w_crc_base >> 8) ^ crc_tab(w_crc_base[7:0] ^ r_hold[3]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) r_hold[i] <= 8'h00;
            r_fill      <= 3'd0;
            r_crc       <= CRC_INIT;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) r_out_byte <= r_hold[3];
            if (w_accept) begin
                r_hold[0] <= in_byte;
                r_hold[1] <= r_hold[0];
                r_hold[2] <= r_hold[1];
                r_hold[3] <= r_hold[2];
                r_fill    <= (w_fill_base == 3'd4) ? 3'd4 : w_fill_base + 3'd1;
                r_crc     <= w_emit ? w_crc_upd : w_crc_base;
                r_len     <= (w_emit && (w_len_base != LEN_MAX)) ? w_len_base + 1'b1 : w_len_base;
            end else if (w_restart) begin
                r_fill <= 3'd0;
                r_crc  <= CRC_INIT;
                r_len  <= '0;
            end
        end
    end

    // hold[0] is the newest byte; the oldest valid held byte lands in lane 0.
    always_comb begin
        w_rx_asm = 32'h0;
        case (r_fill)
            3'd1:    w_rx_asm = {24'h0, r_hold[0]};
            3'd2:    w_rx_asm = {16'h0, r_hold[0], r_hold[1]};
            3'd3:    w_rx_asm = {8'h0, r_hold[0], r_hold[1], r_hold[2]};
            3'd4:    w_rx_asm = {r_hold[0], r_hold[1], r_hold[2], r_hold[3]};
            default: w_rx_asm = 32'h0;
        endcase
    end

    assign w_is_runt = (r_fill < 3'd4);
    assign w_calc    = w_is_runt ? 32'h0 : ~r_crc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_ok  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_runt      <= 1'b0;
            r_rx_crc    <= 32'h0;
            r_calc_crc  <= 32'h0;
            r_frame_len <= '0;
        end else if (r_state == ST_CHECK) begin
            r_frame_ok  <= !w_is_runt && (w_calc == w_rx_asm);
            r_crc_err   <= !w_is_runt && (w_calc != w_rx_asm);
            r_runt      <= w_is_runt;
            r_rx_crc    <= w_rx_asm;
            r_calc_crc  <= w_calc;
            r_frame_len <= w_is_runt ? '0 : r_len;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_byte   = r_out_byte;
    assign frame_done = w_frame_done;
    assign frame_ok   = r_frame_ok;
    assign crc_err    = r_crc_err;
    assign runt       = r_runt;
    assign rx_crc     = r_rx_crc;
    assign calc_crc   = r_calc_crc;
    assign frame_len  = r_frame_len;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Bench for crc32_frame_checker: directed frames from the test plan plus random
// frames, checked every cycle against a frame-level model.
module tb_crc32_frame_checker;

    localparam int LEN_W   = 4;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_byte;
    logic             frame_done;
    logic             frame_ok;
    logic             crc_err;
    logic             runt;
    logic [31:0]      rx_crc;
    logic [31:0]      calc_crc;
    logic [LEN_W-1:0] frame_len;
    logic [1:0]       dbg_state;

    crc32_frame_checker #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_byte(out_byte),
        .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err), .runt(runt),
        .rx_crc(rx_crc), .calc_crc(calc_crc), .frame_len(frame_len), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    typedef struct {
        logic        ok;
        logic        err;
        logic        rnt;
        logic [31:0] rx;
        logic [31:0] calc;
        int unsigned len;
    } rep_t;

    logic [31:0] tab [256];
    logic [7:0]  exp_q [$];
    rep_t        rep_q [$];
    rep_t        held;
    int          chk_cyc = -10;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_tab();
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = i;
            for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
            tab[i] = v;
        end
    endfunction

    function automatic logic [31:0] crc_of(input logic [7:0] d [$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) c = (c >> 8) ^ tab[c[7:0] ^ d[i]];
        return ~c;
    endfunction

    // Frame-level expectation: payload bytes and the end-of-frame report.
    function automatic void model_frame(input logic [7:0] f [$]);
        rep_t        r;
        logic [7:0]  pay [$];
        int          n;
        n = f.size();
        r.rx = 32'h0;
        if (n < 4) begin
            r.rnt = 1'b1; r.ok = 1'b0; r.err = 1'b0; r.len = 0; r.calc = 32'h0;
            for (int i = 0; i < n; i++) r.rx[8*i +: 8] = f[i];
        end else begin
            for (int i = 0; i < n - 4; i++) begin
                pay.push_back(f[i]);
                exp_q.push_back(f[i]);
            end
            r.rnt  = 1'b0;
            r.calc = crc_of(pay);
            r.rx   = {f[n-1], f[n-2], f[n-3], f[n-4]};
            r.ok   = (r.calc == r.rx);
            r.err  = !r.ok;
            r.len  = (n - 4 > LEN_MAX) ? LEN_MAX : n - 4;
        end
        rep_q.push_back(r);
    endfunction

    function automatic void add_crc(inout logic [7:0] f [$]);
        logic [31:0] c;
        c = crc_of(f);
        f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic last);
        int w;
        @(negedge clk);
        in_valid = 1'b1; in_byte = b; in_last = last;
        w = 0;
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        if (last) chk_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(1));
        in_byte  = 8'($urandom);
        @(posedge clk);
        #1;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f [$], input int bubble_pct);
        model_frame(f);
        for (int i = 0; i < f.size(); i++) begin
            if ($urandom_range(99) < bubble_pct) idle_cycle();
            send_byte(f[i], i == f.size() - 1);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",   {31'h0, in_ready},   32'h1);
        check("rst_out_valid",  {31'h0, out_valid},  32'h0);
        check("rst_out_byte",   {24'h0, out_byte},   32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_frame_ok",   {31'h0, frame_ok},   32'h0);
        check("rst_crc_err",    {31'h0, crc_err},    32'h0);
        check("rst_runt",       {31'h0, runt},       32'h0);
        check("rst_rx_crc",     rx_crc,              32'h0);
        check("rst_calc_crc",   calc_crc,            32'h0);
        check("rst_frame_len",  32'(frame_len),      32'h0);
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            held = '{ok: 1'b0, err: 1'b0, rnt: 1'b0, rx: 32'h0, calc: 32'h0, len: 0};
        end else begin
            check("in_ready", {31'h0, in_ready}, {31'h0, (cyc != chk_cyc)});
            if (out_valid) begin
                if (exp_q.size() == 0) check("extra_payload", {31'h0, out_valid}, 32'h0);
                else check("payload", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
            end
            if (frame_done) begin
                check("done_cycle", cyc, chk_cyc + 1);
                if (rep_q.size() == 0) check("extra_frame_done", {31'h0, frame_done}, 32'h0);
                else held = rep_q.pop_front();
            end
            check("frame_ok",  {31'h0, frame_ok}, {31'h0, held.ok});
            check("crc_err",   {31'h0, crc_err},  {31'h0, held.err});
            check("runt",      {31'h0, runt},     {31'h0, held.rnt});
            check("rx_crc",    rx_crc,            held.rx);
            check("calc_crc",  calc_crc,          held.calc);
            check("frame_len", 32'(frame_len),    held.len);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] fr [$];
        logic [7:0] pay [$];
        int         kind;
        int         npay;

        build_tab();
        check("model_tab1",   tab[1],   32'h77073096);
        check("model_tab128", tab[128], 32'hEDB88320);
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_check_value", crc_of(pay), 32'hCBF43926);

        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #2 rst = 1'b1;

        // good frame "123456789"
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(fr, 0);
        repeat (4) @(negedge clk);
        check("lit_good_ok",   {31'h0, frame_ok}, 32'h1);
        check("lit_good_calc", calc_crc, 32'hCBF43926);
        check("lit_good_rx",   rx_crc,   32'hCBF43926);
        check("lit_good_len",  32'(frame_len), 32'd9);

        // corrupted final CRC byte
        fr[12] = 8'hCA;
        send_frame(fr, 0);
        repeat (4) @(negedge clk);
        check("lit_bad_err",  {31'h0, crc_err}, 32'h1);
        check("lit_bad_rx",   rx_crc,   32'hCAF43926);
        check("lit_bad_calc", calc_crc, 32'hCBF43926);

        // empty payloads
        fr = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        repeat (4) @(negedge clk);
        check("lit_empty_ok", {31'h0, frame_ok}, 32'h1);
        fr = '{8'h01, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        repeat (4) @(negedge clk);
        check("lit_empty_err", {31'h0, crc_err}, 32'h1);

        // runt
        fr = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 0);
        repeat (4) @(negedge clk);
        check("lit_runt",    {31'h0, runt}, 32'h1);
        check("lit_runt_rx", rx_crc, 32'h00CCBBAA);

        // back-to-back: second frame's first byte lands in the DONE cycle
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(fr, 0);
        fr = '{8'h61, 8'h62, 8'h63};
        add_crc(fr);
        send_frame(fr, 0);
        fr = '{8'h5A};
        send_frame(fr, 0);
        repeat (3) @(negedge clk);

        // payload longer than the length counter can hold
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'($urandom));
        add_crc(fr);
        send_frame(fr, 10);
        repeat (4) @(negedge clk);
        check("lit_len_sat", 32'(frame_len), LEN_MAX);

        // reset after 6 bytes: bytes 0 and 1 have been forwarded by then
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
        exp_q.push_back(fr[0]);
        exp_q.push_back(fr[1]);
        for (int i = 0; i < 6; i++) send_byte(fr[i], 1'b0);
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(fr, 0);
        repeat (4) @(negedge clk);
        check("lit_after_rst_len", 32'(frame_len), 32'd9);

        // random frames
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            kind = $urandom_range(9);
            if (kind == 0) begin
                npay = $urandom_range(3, 1);
                for (int i = 0; i < npay; i++) fr.push_back(8'($urandom));
            end else begin
                npay = $urandom_range(20);
                for (int i = 0; i < npay; i++) fr.push_back(8'($urandom));
                if (kind <= 6) add_crc(fr);
                else for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
            end
            send_frame(fr, 20);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("payload_queue_empty", exp_q.size(), 32'h0);
        check("report_queue_empty",  rep_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crc32_frame_checker.md
# crc32_frame_checker

Receive-side counterpart of the byte-wise CRC-32 generator. It accepts a byte stream framed by `in_last`, where each frame carries its payload followed by the 4-byte CRC the transmitter appended. It forwards the payload bytes with the CRC stripped and recomputes the CRC-32 over them. At end of frame it reports pass/fail, the received and calculated CRCs, and the payload length. It sits between the byte deframer and the decompression front end.

## Interface
- `LEN_W`, default 16: width of the payload length counter.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset); synchronous release assumed by the system.
- `in_valid` input 1: `in_byte` is valid this cycle.
- `in_byte` input 8: received byte.
- `in_last` input 1: qualifies `in_valid`; marks the final byte of the frame (the last CRC byte).
- `in_ready` output 1: a byte is accepted when `in_valid && in_ready`.
- `out_valid` output 1: one-cycle strobe; `out_byte` is a payload byte.
- `out_byte` output 8: forwarded payload byte, in original order.
- `frame_done` output 1: one-cycle strobe; the status outputs are valid.
- `frame_ok` output 1: CRC matched and the frame was not a runt.
- `crc_err` output 1: CRC mismatch on a frame of 4 or more bytes.
- `runt` output 1: frame had fewer than 4 bytes.
- `rx_crc` output 32: CRC taken from the trailing 4 bytes.
- `calc_crc` output 32: final CRC computed over the payload.
- `frame_len` output LEN_W: payload byte count; saturates at 2^LEN_W−1.

## Operation
- **CRC algorithm:** reflected CRC-32, polynomial 0xEDB88320, table-driven, one byte per accepted payload byte.
  - Init: `crc = 0xFFFFFFFF`.
  - Update: `crc = (crc >> 8) ^ T[crc[7:0] ^ b]`.
  - Final value: `calc_crc = ~crc`.
  - The 256×32 table is the standard reflected table (T[1]=0x77073096, T[128]=0xEDB88320).
- **Trailing-byte delay:** a 4-byte shift register `hold[0..3]` plus a fill count `fill` (0..4).
- **On each accepted byte:**
  - If `fill == 4`: the oldest byte `hold[3]` is emitted as payload. It is fed to the CRC, `frame_len` increments (saturating), and it is driven on `out_byte` with `out_valid` the next cycle.
  - In all cases the new byte is shifted in, and `fill` increments, saturating at 4.
- **Received CRC:** the trailing 4 bytes are little-endian, so the first CRC byte on the wire is `rx_crc[7:0]`.
- **States:**
  - `IDLE/RUN`:
    - `in_ready = 1`.
    - An accepted byte with `in_last` set moves the block to `CHECK`.
    - If `fill` (counting the last byte) is below 4, the `runt` flag is latched.
  - `CHECK`:
    - `in_ready = 0`.
    - Compare `~crc` against the assembled `hold` bytes.
    - Register `frame_ok`, `crc_err`, `runt`, `rx_crc`, `calc_crc` and `frame_len`, then go to `DONE`.
  - `DONE`:
    - `frame_done = 1` for this cycle only.
    - `crc` returns to 0xFFFFFFFF; `fill` and the length counter clear.
    - `in_ready = 1`; a byte accepted in this cycle starts the next frame with the cleared state.
    - Return to `RUN`.
- **Runt frame:**
  - `runt = 1`, `frame_ok = 0`, `crc_err = 0`, `frame_len = 0`; no payload is emitted.
  - `rx_crc` holds the held bytes zero-padded in their upper lanes.
  - `calc_crc = 0x00000000`.
- **Exactly 4-byte frame:** empty payload, `calc_crc = 0x00000000`, and `frame_ok = 1` iff all 4 bytes are 0x00.
- **Hold after reporting:** `frame_ok`, `crc_err`, `runt`, `rx_crc`, `calc_crc` and `frame_len` keep their values until the next `CHECK`.

## Timing
- **Reset values:**
  - `in_ready = 1`
  - `out_valid = 0`, `out_byte = 0`
  - `frame_done = 0`, `frame_ok = 0`, `crc_err = 0`, `runt = 0`
  - `rx_crc = 0`, `calc_crc = 0`, `frame_len = 0`
  - Internal: state `RUN`, `fill = 0`, `crc = 0xFFFFFFFF`.
- **Payload latency:** input byte k (0-based) appears on `out_byte` one cycle after byte k+4 is accepted.
- **Throughput:** one byte per cycle within a frame.
- **Frame end:** `in_last` accepted at cycle T gives `CHECK` at T+1 (`in_ready = 0`) and `frame_done` at T+2.
- **Back-to-back frames:** minimum gap is one dead cycle (T+1); the next frame may begin at T+2.
- **`in_valid` during `CHECK`:** ignored, because `in_ready = 0`. The source must hold the byte.
- **Reset mid-frame:** asynchronous reset immediately aborts the frame. No `frame_done` is produced for the partial frame, and no stale payload is emitted after reset is released.
- **`in_last` with `in_valid` low:** ignored.

## Test plan
- **Good frame:** bytes 0x31..0x39 ("123456789") then 26 39 F4 CB with `in_last` → 9 `out_valid` strobes carrying 0x31..0x39, `frame_done` 2 cycles after the last byte, `frame_ok = 1`, `calc_crc = rx_crc = 0xCBF43926`, `frame_len = 9`.
- **Corrupted CRC byte:** same frame with the final byte 0xCA → `crc_err = 1`, `frame_ok = 0`, `rx_crc = 0xCAF43926`, `calc_crc = 0xCBF43926`; payload still forwarded.
- **Empty payload:** frame 00 00 00 00 → no `out_valid`, `frame_ok = 1`, `frame_len = 0`. Frame 01 00 00 00 → `crc_err = 1`.
- **Runt:** 3 bytes AA BB CC with `in_last` → `runt = 1`, `frame_ok = 0`, `crc_err = 0`, `frame_len = 0`, no payload strobes.
- **Back-to-back:** good frame, then in the `DONE` cycle the first byte of a second good frame → `in_ready = 0` only in the `CHECK` cycle; both frames report `frame_ok = 1` and the second frame's CRC is independent of the first.
- **Reset mid-frame:** assert `rst = 0` after 6 bytes of a frame → all outputs at reset values immediately; a subsequent good frame passes with the correct `frame_len`.
